// File: rtl/issue_pkg.sv
// Shared types and constants for the instruction-issue block that feeds a
// multi-cycle CPU from a host-loaded queue.
package issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    GAP   = 2'd3
  } issue_state_t;

  localparam int unsigned DEF_DEPTH        = 8;
  localparam int unsigned DEF_PULSE_CYCLES = 5;
  localparam int unsigned DEF_GAP_CYCLES   = 5;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned ISSUED_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;

endpackage

// File: rtl/instr_issue_if.sv
// Host/CPU-facing signal bundle of instr_issue; the host side is the master.
interface instr_issue_if #(
  parameter int unsigned DEPTH = issue_pkg::DEF_DEPTH
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic                        wr_en;
  logic [issue_pkg::WORD_W-1:0] wr_data;
  logic                        start;
  logic                        full;
  logic [CNT_W-1:0]            count;
  logic [issue_pkg::WORD_W-1:0] instrword;
  logic                        newinstr;
  logic                        busy;
  logic                        done;
  logic                        overflow;
  logic [issue_pkg::ISSUED_W-1:0] issued;

  modport master (
    output wr_en, wr_data, start,
    input  full, count, instrword, newinstr, busy, done, overflow, issued
  );

  modport slave (
    input  wr_en, wr_data, start,
    output full, count, instrword, newinstr, busy, done, overflow, issued
  );
endinterface

// File: rtl/instr_fifo.sv
// Power-of-two instruction queue with registered count/full and a
// combinational head word.
module instr_fifo
  import issue_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WORD_W-1:0]        push_data,
  input  logic                     pop,
  output logic [WORD_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic [CNT_W-1:0]  count_d;

  // Writes while full are dropped here; the caller flags the overflow.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & (count != '0);
  assign count_d = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_issue.sv
// Drains queued instruction words to a multi-cycle CPU as a SETUP/PULSE/GAP
// handshake: word loaded in SETUP, newinstr held for the pulse, then a gap.
module instr_issue
  import issue_pkg::*;
#(
  parameter int unsigned DEPTH        = DEF_DEPTH,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
  input logic          _clock,
  input logic          _reset,
  instr_issue_if.slave bus
);
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned MAX_CYC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CYC_W   = $clog2(MAX_CYC) + 1;

  issue_state_t      state;
  issue_state_t      state_d;
  logic [CYC_W-1:0]  cyc_q;
  logic [CYC_W-1:0]  cyc_d;
  logic              pop_c;
  logic              done_d;
  logic              issue_c;
  logic              push_ok_c;
  logic [WORD_W-1:0] head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (_clock),
    .rst       (_reset),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (pop_c),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  assign bus.count = fifo_count;
  assign bus.full  = fifo_full;
  assign push_ok_c = bus.wr_en & ~fifo_full;

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state <= IDLE;
      cyc_q <= '0;
    end else begin
      state <= state_d;
      cyc_q <= cyc_d;
    end
  end

  // One down-counter times both PULSE and GAP, reloaded on entry to each.
  always_comb begin
    state_d = state;
    cyc_d   = cyc_q;
    pop_c   = 1'b0;
    done_d  = 1'b0;
    issue_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (fifo_count != '0) state_d = SETUP;
          else                  done_d  = 1'b1;
        end
      end
      SETUP: begin
        pop_c   = 1'b1;
        issue_c = 1'b1;
        state_d = PULSE;
        cyc_d   = CYC_W'(PULSE_CYCLES - 1);
      end
      PULSE: begin
        if (cyc_q == '0) begin
          state_d = GAP;
          cyc_d   = CYC_W'(GAP_CYCLES - 1);
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      GAP: begin
        if (cyc_q == '0) begin
          // A word arriving on this very edge still belongs to the drain.
          if ((fifo_count != '0) || push_ok_c) begin
            state_d = SETUP;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // newinstr lags the state by a cycle so it never moves with instrword.
  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      bus.instrword <= '0;
      bus.newinstr  <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.issued    <= '0;
    end else begin
      if (pop_c) bus.instrword <= head;
      bus.newinstr <= (state == PULSE);
      bus.busy     <= (state_d != IDLE);
      bus.done     <= done_d;
      bus.overflow <= bus.overflow | (bus.wr_en & fifo_full);
      bus.issued   <= bus.issued + ISSUED_W'(issue_c);
    end
  end

endmodule
